// File: rtl/cc_branch_unit.sv
// ============================================================================
// Module   : cc_branch_unit
// Brief    : LC-3 N/Z/P condition codes, registered BEN and an NZP
//            save/restore stack. Define CC_BYPASS_EN to evaluate BEN against
//            the next-state flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cc_branch_unit #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] BUS,
    input  logic             LD_CC,
    input  logic             LD_BEN,
    input  logic [2:0]       IR_NZP,
    input  logic             SAVE,
    input  logic             RESTORE,
    output logic             N,
    output logic             Z,
    output logic             P,
    output logic             BEN,
    output logic             STACK_EMPTY,
    output logic             STACK_FULL,
    output logic             STACK_ERR
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [2:0] C_NZP_RESET = 3'b010;

    logic [2:0]    nzp_q, nzp_d;
    logic          ben_q, ben_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [2:0]    stack_q [STACK_DEPTH];

    logic [2:0]    w_cls;
    logic [2:0]    w_ben_src;
    logic [2:0]    w_top;
    logic [IW-1:0] w_top_idx;
    logic [IW-1:0] w_push_idx;
    logic          w_empty, w_full;
    logic          w_push_ok, w_pop_ok, w_err_set;

    assign w_empty    = (count_q == '0);
    assign w_full     = (count_q == CW'(STACK_DEPTH));
    assign w_top_idx  = IW'(count_q - CW'(1));
    assign w_push_idx = IW'(count_q);
    assign w_top      = stack_q[w_top_idx];

    always_comb begin
        w_cls = 3'b001;
        if (BUS == '0) begin
            w_cls = 3'b010;
        end else if (BUS[WIDTH-1]) begin
            w_cls = 3'b100;
        end
    end

    // A colliding SAVE+RESTORE touches neither the stack nor the flags.
    assign w_push_ok = SAVE & ~RESTORE & ~w_full;
    assign w_pop_ok  = RESTORE & ~SAVE & ~w_empty;
    assign w_err_set = (SAVE & RESTORE) | (SAVE & w_full) | (RESTORE & w_empty);

    always_comb begin
        nzp_d = nzp_q;
        if (w_pop_ok) begin
            nzp_d = w_top;
        end else if (LD_CC) begin
            nzp_d = w_cls;
        end
    end

    always_comb begin
        count_d = count_q;
        if (w_push_ok) begin
            count_d = count_q + CW'(1);
        end else if (w_pop_ok) begin
            count_d = count_q - CW'(1);
        end
    end

`ifdef CC_BYPASS_EN
    assign w_ben_src = nzp_d;
`else
    assign w_ben_src = nzp_q;
`endif

    always_comb begin
        ben_d = ben_q;
        if (LD_BEN) begin
            ben_d = |(w_ben_src & IR_NZP);
        end
    end

    assign err_d = err_q | w_err_set;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            nzp_q   <= C_NZP_RESET;
            ben_q   <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            nzp_q   <= nzp_d;
            ben_q   <= ben_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Entries above count are don't-care, so the storage needs no reset.
    always_ff @(posedge CLK) begin
        if (RST_N && w_push_ok) begin
            stack_q[w_push_idx] <= nzp_q;
        end
    end

    assign N           = nzp_q[2];
    assign Z           = nzp_q[1];
    assign P           = nzp_q[0];
    assign BEN         = ben_q;
    assign STACK_EMPTY = w_empty;
    assign STACK_FULL  = w_full;
    assign STACK_ERR   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cc_branch_unit.sv
// ============================================================================
// Module   : tb_cc_branch_unit
// Brief    : Directed self-checking bench for cc_branch_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cc_branch_unit;

    logic        CLK;
    logic        RST_N;
    logic [15:0] BUS;
    logic        LD_CC, LD_BEN, SAVE, RESTORE;
    logic [2:0]  IR_NZP;
    logic        N, Z, P, BEN, STACK_EMPTY, STACK_FULL, STACK_ERR;

    int checks = 0;
    int errors = 0;

`ifdef CC_BYPASS_EN
    localparam logic C_BYPASS_BEN = 1'b1;
`else
    localparam logic C_BYPASS_BEN = 1'b0;
`endif

    cc_branch_unit #(.WIDTH(16), .STACK_DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .BUS(BUS), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
        .IR_NZP(IR_NZP), .SAVE(SAVE), .RESTORE(RESTORE),
        .N(N), .Z(Z), .P(P), .BEN(BEN),
        .STACK_EMPTY(STACK_EMPTY), .STACK_FULL(STACK_FULL), .STACK_ERR(STACK_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        LD_CC = 0; LD_BEN = 0; SAVE = 0; RESTORE = 0;
    endtask

    initial begin
        RST_N = 0; BUS = '0; IR_NZP = 3'b000;
        idle();
        tick(); tick();
        RST_N = 1;
        chk("reset_nzp",   {5'd0, N, Z, P}, 8'h02);
        chk("reset_ben",   {7'd0, BEN}, 8'h00);
        chk("reset_empty", {7'd0, STACK_EMPTY}, 8'h01);
        chk("reset_full",  {7'd0, STACK_FULL}, 8'h00);
        chk("reset_err",   {7'd0, STACK_ERR}, 8'h00);

        // Classification and BEN
        LD_CC = 1; BUS = 16'h8000; tick();
        chk("ldcc_neg", {5'd0, N, Z, P}, 8'h04);
        BUS = 16'h0001; tick();
        chk("ldcc_pos", {5'd0, N, Z, P}, 8'h01);
        LD_CC = 0; BUS = 16'h0000; tick();
        chk("ldcc_hold", {5'd0, N, Z, P}, 8'h01);
        LD_BEN = 1; IR_NZP = 3'b100; tick();
        chk("ben_100", {7'd0, BEN}, 8'h00);
        IR_NZP = 3'b001; tick();
        chk("ben_001", {7'd0, BEN}, 8'h01);
        IR_NZP = 3'b111; tick();
        chk("ben_111", {7'd0, BEN}, 8'h01);
        IR_NZP = 3'b000; tick();
        chk("ben_000", {7'd0, BEN}, 8'h00);
        LD_BEN = 0; IR_NZP = 3'b111; tick();
        chk("ben_hold", {7'd0, BEN}, 8'h00);

        // Basic save/restore
        LD_CC = 1; BUS = 16'h8000; tick();
        LD_CC = 0; SAVE = 1; tick();
        chk("push1_empty", {7'd0, STACK_EMPTY}, 8'h00);
        SAVE = 0; LD_CC = 1; BUS = 16'h0005; tick();
        LD_CC = 0; SAVE = 1; tick();
        SAVE = 0; LD_CC = 1; BUS = 16'h0000; tick();
        chk("load_z", {5'd0, N, Z, P}, 8'h02);
        LD_CC = 0; RESTORE = 1; tick();
        chk("restore_p", {5'd0, N, Z, P}, 8'h01);
        tick();
        chk("restore_n", {5'd0, N, Z, P}, 8'h04);
        RESTORE = 0;
        chk("restore_empty", {7'd0, STACK_EMPTY}, 8'h01);
        chk("restore_err",   {7'd0, STACK_ERR}, 8'h00);

        // Fill to overflow; SAVE+LD_CC pushes old flags and loads new ones
        SAVE = 1; LD_CC = 1;
        BUS = 16'h0001; tick();
        BUS = 16'h0000; tick();
        BUS = 16'h8000; tick();
        BUS = 16'h0001; tick();
        chk("full_flag", {7'd0, STACK_FULL}, 8'h01);
        chk("full_noerr", {7'd0, STACK_ERR}, 8'h00);
        chk("full_nzp", {5'd0, N, Z, P}, 8'h01);
        LD_CC = 0; tick();
        chk("overflow_err", {7'd0, STACK_ERR}, 8'h01);
        chk("overflow_full", {7'd0, STACK_FULL}, 8'h01);
        SAVE = 0; RESTORE = 1; tick();
        chk("pop4", {5'd0, N, Z, P}, 8'h04);
        chk("pop4_full", {7'd0, STACK_FULL}, 8'h00);
        tick();
        chk("pop3", {5'd0, N, Z, P}, 8'h02);
        LD_CC = 1; BUS = 16'h8000; tick();
        chk("pop_beats_ldcc", {5'd0, N, Z, P}, 8'h01);
        LD_CC = 0; tick();
        chk("pop1", {5'd0, N, Z, P}, 8'h04);
        chk("pop1_empty", {7'd0, STACK_EMPTY}, 8'h01);

        // Reset mid-sequence overrides all inputs
        RST_N = 0; RESTORE = 0; SAVE = 1; LD_CC = 1; LD_BEN = 1; IR_NZP = 3'b111;
        BUS = 16'h8000; tick();
        chk("midrst_nzp", {5'd0, N, Z, P}, 8'h02);
        chk("midrst_err", {7'd0, STACK_ERR}, 8'h00);
        chk("midrst_empty", {7'd0, STACK_EMPTY}, 8'h01);
        chk("midrst_ben", {7'd0, BEN}, 8'h00);
        RST_N = 1; idle();

        // Underflow and collision
        RESTORE = 1; tick();
        chk("underflow_nzp", {5'd0, N, Z, P}, 8'h02);
        chk("underflow_err", {7'd0, STACK_ERR}, 8'h01);
        LD_CC = 1; BUS = 16'h8000; tick();
        chk("failpop_ldcc", {5'd0, N, Z, P}, 8'h04);
        LD_CC = 0; SAVE = 1; tick();
        chk("collide_nzp", {5'd0, N, Z, P}, 8'h04);
        chk("collide_empty", {7'd0, STACK_EMPTY}, 8'h01);
        idle(); tick(); tick();
        chk("err_sticky", {7'd0, STACK_ERR}, 8'h01);

        // BEN with a coincident flag update
        RST_N = 0; tick(); RST_N = 1;
        LD_CC = 1; LD_BEN = 1; IR_NZP = 3'b100; BUS = 16'hFFFF; tick();
        chk("bypass_ben", {7'd0, BEN}, {7'd0, C_BYPASS_BEN});
        chk("bypass_nzp", {5'd0, N, Z, P}, 8'h04);
        idle(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
